cva6_axi_quiesce_ctrl: RTL and testbench

//  Sits on the CVA6-cluster AXI master path, between the ID remapper and the CDC source FIFO.
//  - Tracks outstanding read/write transactions.
//  - Caps in-flight requests.
//  - On request, quiesces the port: blocks new AW/AR, drains W/B/R, then acknowledges

---
 rtl/cva6_axi_quiesce_ctrl_pkg.sv | 20 ++
 rtl/cva6_axi_quiesce_ctrl_txn_counter.sv | 45 ++++
 rtl/cva6_axi_quiesce_ctrl.sv | 148 ++++++++++++++
 tb/tb_cva6_axi_quiesce_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cva6_axi_quiesce_ctrl_pkg.sv
// Shared types and defaults for the CVA6 AXI quiesce controller.
// Holds the port-state enum and the indices of the three transaction counters.
package cva6_quiesce_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2
    } qstate_e;

    localparam int unsigned DEFAULT_MAX_OUTSTANDING = 8;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES  = 1024;

    // Slots in the counter bank: reads, writes (AW..B), write data pending (AW..W-last)
    localparam int unsigned CNT_RD    = 0;
    localparam int unsigned CNT_WR    = 1;
    localparam int unsigned CNT_WPEND = 2;
    localparam int unsigned NUM_CNT   = 3;

endpackage

// File: rtl/cva6_axi_quiesce_ctrl_txn_counter.sv
// Up/down in-flight transaction counter; a decrement at zero saturates
// and raises a one-cycle underflow flag for the owner to latch.
module axi_txn_counter
    import cva6_quiesce_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 underflow_o
);

    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [CNT_WIDTH-1:0] cnt_next;

    always_comb begin
        cnt_next    = cnt_reg;
        underflow_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (cnt_reg != '1) begin
                cnt_next = cnt_reg + CNT_WIDTH'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (cnt_reg == '0) begin
                underflow_o = 1'b1;
            end else begin
                cnt_next = cnt_reg - CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt_o = cnt_reg;

endmodule

// File: rtl/cva6_axi_quiesce_ctrl.sv
// AXI master-path quiesce controller: caps and tracks in-flight transactions,
// and on request blocks new AW/AR, drains W/B/R, then acknowledges isolation.
module cva6_axi_quiesce_ctrl
    import cva6_quiesce_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
    parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1),
    parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 isolate_req_i,
    output logic                 isolate_ack_o,
    output logic                 drain_timeout_o,
    output logic                 protocol_err_o,
    output logic [CNT_WIDTH-1:0] outstanding_rd_o,
    output logic [CNT_WIDTH-1:0] outstanding_wr_o,
    input  logic                 slv_aw_valid_i,
    output logic                 slv_aw_ready_o,
    output logic                 mst_aw_valid_o,
    input  logic                 mst_aw_ready_i,
    input  logic                 slv_ar_valid_i,
    output logic                 slv_ar_ready_o,
    output logic                 mst_ar_valid_o,
    input  logic                 mst_ar_ready_i,
    input  logic                 slv_w_valid_i,
    input  logic                 slv_w_last_i,
    output logic                 slv_w_ready_o,
    output logic                 mst_w_valid_o,
    input  logic                 mst_w_ready_i,
    input  logic                 mst_b_valid_i,
    output logic                 mst_b_ready_o,
    output logic                 slv_b_valid_o,
    input  logic                 slv_b_ready_i,
    input  logic                 mst_r_valid_i,
    input  logic                 mst_r_last_i,
    output logic                 mst_r_ready_o,
    output logic                 slv_r_valid_o,
    input  logic                 slv_r_ready_i
);

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam int unsigned          TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]     TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    qstate_e              state_reg, state_next;
    logic [TMO_W-1:0]     tmo_reg, tmo_next;
    logic                 ack_reg, timeout_reg, err_reg;

    logic [NUM_CNT-1:0]   inc_vec, dec_vec, uf_vec;
    logic [CNT_WIDTH-1:0] cnt_arr [NUM_CNT];

    logic open_aw, open_ar, open_w, live, idle;
    logic aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;

    assign live = ~rst_i;

    // Gates look only at registered state/counters, so there is no valid->ready path.
    assign open_aw = (state_reg == RUN) && (cnt_arr[CNT_WR] < MAX_CNT);
    assign open_ar = (state_reg == RUN) && (cnt_arr[CNT_RD] < MAX_CNT);
    assign open_w  = (cnt_arr[CNT_WPEND] != '0);

    assign mst_aw_valid_o = slv_aw_valid_i & open_aw & live;
    assign slv_aw_ready_o = mst_aw_ready_i & open_aw & live;
    assign mst_ar_valid_o = slv_ar_valid_i & open_ar & live;
    assign slv_ar_ready_o = mst_ar_ready_i & open_ar & live;
    assign mst_w_valid_o  = slv_w_valid_i & open_w & live;
    assign slv_w_ready_o  = mst_w_ready_i & open_w & live;
    assign slv_b_valid_o  = mst_b_valid_i & live;
    assign mst_b_ready_o  = slv_b_ready_i & live;
    assign slv_r_valid_o  = mst_r_valid_i & live;
    assign mst_r_ready_o  = slv_r_ready_i & live;

    assign aw_hs     = slv_aw_valid_i & mst_aw_ready_i & open_aw & live;
    assign ar_hs     = slv_ar_valid_i & mst_ar_ready_i & open_ar & live;
    assign w_last_hs = slv_w_valid_i & mst_w_ready_i & slv_w_last_i & open_w & live;
    assign b_hs      = mst_b_valid_i & slv_b_ready_i & live;
    assign r_last_hs = mst_r_valid_i & slv_r_ready_i & mst_r_last_i & live;

    assign inc_vec[CNT_RD]    = ar_hs;
    assign dec_vec[CNT_RD]    = r_last_hs;
    assign inc_vec[CNT_WR]    = aw_hs;
    assign dec_vec[CNT_WR]    = b_hs;
    assign inc_vec[CNT_WPEND] = aw_hs;
    assign dec_vec[CNT_WPEND] = w_last_hs;

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            axi_txn_counter #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_cnt (
                .clk_i       (clk_i),
                .rst_i       (rst_i),
                .inc_i       (inc_vec[gi]),
                .dec_i       (dec_vec[gi]),
                .cnt_o       (cnt_arr[gi]),
                .underflow_o (uf_vec[gi])
            );
        end
    endgenerate

    assign idle = (cnt_arr[CNT_RD] == '0) && (cnt_arr[CNT_WR] == '0)
               && (cnt_arr[CNT_WPEND] == '0);

    always_comb begin
        state_next = state_reg;
        tmo_next   = '0;
        case (state_reg)
            RUN:      if (isolate_req_i) state_next = DRAIN;
            DRAIN: begin
                if (!isolate_req_i) begin
                    state_next = RUN;
                end else if (idle) begin
                    state_next = ISOLATED;
                end
            end
            ISOLATED: if (!isolate_req_i) state_next = RUN;
            default:  state_next = RUN;
        endcase
        // Timeout only observes the drain; it never forces a transition.
        if (state_reg == DRAIN && state_next == DRAIN) begin
            tmo_next = (tmo_reg == TMO_MAX) ? tmo_reg : tmo_reg + TMO_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= RUN;
            tmo_reg     <= '0;
            ack_reg     <= 1'b0;
            timeout_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tmo_reg     <= tmo_next;
            ack_reg     <= (state_next == ISOLATED);
            timeout_reg <= (tmo_next == TMO_MAX);
            err_reg     <= err_reg | (|uf_vec);
        end
    end

    assign isolate_ack_o    = ack_reg;
    assign drain_timeout_o  = timeout_reg;
    assign protocol_err_o   = err_reg;
    assign outstanding_rd_o = cnt_arr[CNT_RD];
    assign outstanding_wr_o = cnt_arr[CNT_WR];

endmodule

// File: tb/tb_cva6_axi_quiesce_ctrl.sv
// Scoreboard bench for cva6_axi_quiesce_ctrl: expectations are queued as stimulus
// is driven and popped against the DUT at the following falling clock edge.
module tb_cva6_axi_quiesce_ctrl;

    localparam int unsigned MAXO = 8;
    localparam int unsigned TMO  = 16;
    localparam int unsigned CW   = $clog2(MAXO + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          isolate_req, isolate_ack, drain_timeout, protocol_err;
    logic [CW-1:0] outstanding_rd, outstanding_wr;
    logic          slv_aw_valid, slv_aw_ready, mst_aw_valid, mst_aw_ready;
    logic          slv_ar_valid, slv_ar_ready, mst_ar_valid, mst_ar_ready;
    logic          slv_w_valid, slv_w_last, slv_w_ready, mst_w_valid, mst_w_ready;
    logic          mst_b_valid, mst_b_ready, slv_b_valid, slv_b_ready;
    logic          mst_r_valid, mst_r_last, mst_r_ready, slv_r_valid, slv_r_ready;

    always #5 clk = ~clk;

    cva6_axi_quiesce_ctrl #(
        .MAX_OUTSTANDING (MAXO),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .isolate_req_i    (isolate_req),
        .isolate_ack_o    (isolate_ack),
        .drain_timeout_o  (drain_timeout),
        .protocol_err_o   (protocol_err),
        .outstanding_rd_o (outstanding_rd),
        .outstanding_wr_o (outstanding_wr),
        .slv_aw_valid_i   (slv_aw_valid),
        .slv_aw_ready_o   (slv_aw_ready),
        .mst_aw_valid_o   (mst_aw_valid),
        .mst_aw_ready_i   (mst_aw_ready),
        .slv_ar_valid_i   (slv_ar_valid),
        .slv_ar_ready_o   (slv_ar_ready),
        .mst_ar_valid_o   (mst_ar_valid),
        .mst_ar_ready_i   (mst_ar_ready),
        .slv_w_valid_i    (slv_w_valid),
        .slv_w_last_i     (slv_w_last),
        .slv_w_ready_o    (slv_w_ready),
        .mst_w_valid_o    (mst_w_valid),
        .mst_w_ready_i    (mst_w_ready),
        .mst_b_valid_i    (mst_b_valid),
        .mst_b_ready_o    (mst_b_ready),
        .slv_b_valid_o    (slv_b_valid),
        .slv_b_ready_i    (slv_b_ready),
        .mst_r_valid_i    (mst_r_valid),
        .mst_r_last_i     (mst_r_last),
        .mst_r_ready_o    (mst_r_ready),
        .slv_r_valid_o    (slv_r_valid),
        .slv_r_ready_i    (slv_r_ready)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_run  = 0;
    int   n_fail = 0;
    int   rd_model;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_underrun", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        isolate_req  = 1'b0;
        slv_aw_valid = 1'b0; mst_aw_ready = 1'b1;
        slv_ar_valid = 1'b0; mst_ar_ready = 1'b1;
        slv_w_valid  = 1'b0; slv_w_last   = 1'b0; mst_w_ready = 1'b1;
        mst_b_valid  = 1'b0; slv_b_ready  = 1'b1;
        mst_r_valid  = 1'b0; mst_r_last   = 1'b0; slv_r_ready = 1'b1;
    endtask

    function automatic logic [9:0] gate_vec();
        return {mst_aw_valid, mst_ar_valid, mst_w_valid, slv_aw_ready, slv_ar_ready,
                slv_w_ready, slv_b_valid, slv_r_valid, mst_b_ready, mst_r_ready};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. reset with every input high
        rst = 1'b1;
        isolate_req  = 1'b1;
        slv_aw_valid = 1'b1; mst_aw_ready = 1'b1;
        slv_ar_valid = 1'b1; mst_ar_ready = 1'b1;
        slv_w_valid  = 1'b1; slv_w_last   = 1'b1; mst_w_ready = 1'b1;
        mst_b_valid  = 1'b1; slv_b_ready  = 1'b1;
        mst_r_valid  = 1'b1; mst_r_last   = 1'b1; slv_r_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb_push($sformatf("rst_gates_%0d", i), 32'd0);
            @(negedge clk);
            sb_pop(32'(gate_vec()));
            next_cycle();
        end
        rst = 1'b0;
        idle_inputs();
        sb_push("rst_rd", 0); sb_push("rst_wr", 0); sb_push("rst_ack", 0);
        sb_push("rst_err", 0); sb_push("rst_tmo", 0);
        @(negedge clk);
        sb_pop(32'(outstanding_rd)); sb_pop(32'(outstanding_wr)); sb_pop(32'(isolate_ack));
        sb_pop(32'(protocol_err));   sb_pop(32'(drain_timeout));
        next_cycle();

        // 2. nine back-to-back ARs with no read data returning
        rd_model = 0;
        slv_ar_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            sb_push($sformatf("ar_ready_%0d", i), 32'(rd_model < int'(MAXO)));
            @(negedge clk);
            sb_pop(32'(slv_ar_ready));
            if (rd_model < int'(MAXO)) rd_model++;
            next_cycle();
        end
        sb_push("rd_full", 32'(rd_model));
        mst_r_valid = 1'b1; mst_r_last = 1'b1;
        sb_push("ar_ready_with_r", 0);
        @(negedge clk);
        sb_pop(32'(outstanding_rd));
        sb_pop(32'(slv_ar_ready));
        rd_model--;
        next_cycle();
        mst_r_valid = 1'b0; mst_r_last = 1'b0;
        sb_push("ar_reopen", 1);
        @(negedge clk);
        sb_pop(32'(slv_ar_ready));
        rd_model++;
        next_cycle();
        slv_ar_valid = 1'b0;
        sb_push("rd_refill", 32'(rd_model));
        @(negedge clk);
        sb_pop(32'(outstanding_rd));
        mst_r_valid = 1'b1; mst_r_last = 1'b1;
        for (int i = 0; i < int'(MAXO); i++) begin
            next_cycle();
            rd_model--;
        end
        idle_inputs();
        sb_push("rd_drained", 32'(rd_model));
        @(negedge clk);
        sb_pop(32'(outstanding_rd));
        next_cycle();

        // 3. two writes in flight, then isolate: AW blocked, W drains, ack after B
        slv_aw_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb_push($sformatf("aw_ready_%0d", i), 1);
            @(negedge clk);
            sb_pop(32'(slv_aw_ready));
            next_cycle();
        end
        slv_aw_valid = 1'b0;
        isolate_req  = 1'b1;
        sb_push("wr_two", 2);
        @(negedge clk);
        sb_pop(32'(outstanding_wr));
        next_cycle();
        slv_aw_valid = 1'b1;
        slv_w_valid  = 1'b1; slv_w_last = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb_push($sformatf("drain_aw_blocked_%0d", i), 0);
            sb_push($sformatf("drain_w_fwd_%0d", i), 1);
            @(negedge clk);
            sb_pop(32'(mst_aw_valid));
            sb_pop(32'(mst_w_valid));
            next_cycle();
        end
        slv_aw_valid = 1'b0;
        slv_w_valid  = 1'b0; slv_w_last = 1'b0;
        mst_b_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb_push($sformatf("drain_ack_b%0d", i), 0);
            @(negedge clk);
            sb_pop(32'(isolate_ack));
            next_cycle();
        end
        mst_b_valid = 1'b0;
        sb_push("drain_wr_zero", 0);
        sb_push("drain_ack_pre", 0);
        @(negedge clk);
        sb_pop(32'(outstanding_wr));
        sb_pop(32'(isolate_ack));
        next_cycle();
        sb_push("drain_ack_set", 1);
        sb_push("drain_err_clean", 0);
        @(negedge clk);
        sb_pop(32'(isolate_ack));
        sb_pop(32'(protocol_err));
        next_cycle();
        isolate_req = 1'b0;
        next_cycle();
        sb_push("drain_ack_release", 0);
        @(negedge clk);
        sb_pop(32'(isolate_ack));
        next_cycle();

        // 4. idle port: ack two cycles after request, AR passes once released
        isolate_req = 1'b1;
        sb_push("idle_ack_t0", 0);
        @(negedge clk);
        sb_pop(32'(isolate_ack));
        next_cycle();
        sb_push("idle_ack_t1", 0);
        @(negedge clk);
        sb_pop(32'(isolate_ack));
        next_cycle();
        slv_ar_valid = 1'b1;
        sb_push("idle_ack_t2", 1);
        sb_push("iso_ar_blocked", 0);
        @(negedge clk);
        sb_pop(32'(isolate_ack));
        sb_pop(32'(mst_ar_valid));
        slv_ar_valid = 1'b0;
        next_cycle();
        isolate_req = 1'b0;
        next_cycle();
        slv_ar_valid = 1'b1;
        sb_push("rel_ack", 0);
        sb_push("rel_ar_pass", 1);
        @(negedge clk);
        sb_pop(32'(isolate_ack));
        sb_pop(32'(mst_ar_valid));
        next_cycle();
        slv_ar_valid = 1'b0;

        // 5. one read left unanswered while draining: timeout after TMO cycles
        isolate_req = 1'b1;
        next_cycle();
        for (int k = 1; k <= int'(TMO); k++) begin
            next_cycle();
            sb_push($sformatf("tmo_k%0d", k), 32'(k >= int'(TMO)));
            @(negedge clk);
            sb_pop(32'(drain_timeout));
        end
        next_cycle();
        sb_push("tmo_hold", 1);
        sb_push("tmo_no_ack", 0);
        @(negedge clk);
        sb_pop(32'(drain_timeout));
        sb_pop(32'(isolate_ack));
        isolate_req = 1'b0;
        next_cycle();
        sb_push("tmo_cleared", 0);
        sb_push("tmo_run_ar_open", 1);
        @(negedge clk);
        sb_pop(32'(drain_timeout));
        sb_pop(32'(slv_ar_ready));
        mst_r_valid = 1'b1; mst_r_last = 1'b1;
        next_cycle();
        idle_inputs();
        sb_push("tmo_rd_zero", 0);
        @(negedge clk);
        sb_pop(32'(outstanding_rd));
        next_cycle();

        // 6. stray B sets the sticky error; W held back until after its AW
        mst_b_valid = 1'b1;
        next_cycle();
        mst_b_valid = 1'b0;
        sb_push("err_set", 1);
        sb_push("err_wr_zero", 0);
        @(negedge clk);
        sb_pop(32'(protocol_err));
        sb_pop(32'(outstanding_wr));
        next_cycle();
        slv_w_valid = 1'b1; slv_w_last = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb_push($sformatf("w_early_%0d", i), 0);
            @(negedge clk);
            sb_pop(32'(mst_w_valid));
            next_cycle();
        end
        slv_aw_valid = 1'b1;
        sb_push("w_at_aw", 0);
        sb_push("aw_hs", 1);
        @(negedge clk);
        sb_pop(32'(mst_w_valid));
        sb_pop(32'(slv_aw_ready));
        next_cycle();
        slv_aw_valid = 1'b0;
        sb_push("w_after_aw", 1);
        @(negedge clk);
        sb_pop(32'(mst_w_valid));
        next_cycle();
        slv_w_valid = 1'b0; slv_w_last = 1'b0;
        mst_b_valid = 1'b1;
        next_cycle();
        mst_b_valid = 1'b0;
        sb_push("err_sticky", 1);
        sb_push("wr_final", 0);
        @(negedge clk);
        sb_pop(32'(protocol_err));
        sb_pop(32'(outstanding_wr));

        if (sb_q.size() != 0) check_val("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
